engine_sched: RTL and testbench

Slot scheduler for a SHA-256 engine of `N_CORES` two-thread cores. It gives each thread one fixed start slot per `FRAME`-cycle frame and issues a core start only when that thread has a block pending. It tracks which threads are in flight and reports completions one frame after each start. It replaces free-running start generation: empty slots are skipped, and requesters get an explicit ack and done handshake.

---
 rtl/engine_sched_if.sv | 24 ++
 rtl/engine_sched.sv | 85 ++++++++
 tb/tb_engine_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/engine_sched_if.sv
// Requester/scheduler handshake bundle for engine_sched: per-thread request, ack and done,
// per-core start/seq strobes, plus the global enable and idle status.
interface engine_sched_if #(
    parameter int unsigned N_CORES   = 3,
    parameter int unsigned N_THREADS = 2 * N_CORES
);
    logic                 en;
    logic [N_THREADS-1:0] thread_req;
    logic [N_THREADS-1:0] thread_ack;
    logic [N_THREADS-1:0] thread_done;
    logic [N_CORES-1:0]   core_start;
    logic [N_CORES-1:0]   core_seq;
    logic                 idle;

    modport master (
        output en, thread_req,
        input  thread_ack, thread_done, core_start, core_seq, idle
    );

    modport slave (
        input  en, thread_req,
        output thread_ack, thread_done, core_start, core_seq, idle
    );
endinterface

// File: rtl/engine_sched.sv
// Fixed-slot start scheduler for two-thread SHA-256 cores: one start slot per thread per frame,
// issued only on request, with completion reported exactly one frame after each start.
module engine_sched #(
    parameter int unsigned N_CORES       = 3,
    parameter int unsigned N_THREADS     = 2 * N_CORES,
    parameter int unsigned FRAME         = 144,
    parameter int unsigned COMP_INTERVAL = FRAME / N_THREADS
) (
    input logic           CLK,
    input logic           reset,
    engine_sched_if.slave bus
);
    logic [7:0]           r_cnt;
    logic [N_THREADS-1:0] r_busy;
    logic [N_THREADS-1:0] r_ack;
    logic [N_THREADS-1:0] r_done;
    logic [N_CORES-1:0]   r_start;
    logic [N_CORES-1:0]   r_seq;
    logic                 r_idle;

    logic [7:0]           w_cnt_nxt;
    logic [N_THREADS-1:0] w_hit;
    logic [N_THREADS-1:0] w_go;
    logic [N_THREADS-1:0] w_fin;
    logic [N_THREADS-1:0] w_busy_nxt;
    logic [N_CORES-1:0]   w_start_nxt;
    logic [N_CORES-1:0]   w_seq_nxt;

    function automatic logic [7:0] slot_of(input int unsigned c, input int unsigned s);
        int unsigned v;
        v = s * (FRAME / 2) + c * COMP_INTERVAL;
        return v[7:0];
    endfunction

    always_comb begin
        w_cnt_nxt   = (r_cnt == 8'(FRAME - 1)) ? '0 : r_cnt + 8'd1;
        w_hit       = '0;
        w_go        = '0;
        w_fin       = '0;
        w_busy_nxt  = r_busy;
        w_start_nxt = '0;
        w_seq_nxt   = r_seq;
        for (int unsigned c = 0; c < N_CORES; c++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                // A thread's own slot always ends its previous run; a new start may re-arm it.
                w_hit[s*N_CORES+c]      = (r_cnt == slot_of(c, s));
                w_fin[s*N_CORES+c]      = w_hit[s*N_CORES+c] & r_busy[s*N_CORES+c];
                w_go[s*N_CORES+c]       = w_hit[s*N_CORES+c] & bus.thread_req[s*N_CORES+c] & bus.en;
                if (w_hit[s*N_CORES+c]) begin
                    w_busy_nxt[s*N_CORES+c] = w_go[s*N_CORES+c];
                end
                if (w_go[s*N_CORES+c]) begin
                    w_start_nxt[c] = 1'b1;
                    w_seq_nxt[c]   = (s != 0);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cnt   <= '0;
            r_busy  <= '0;
            r_ack   <= '0;
            r_done  <= '0;
            r_start <= '0;
            r_seq   <= '0;
            r_idle  <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_ack   <= w_go;
            r_done  <= w_fin;
            r_start <= w_start_nxt;
            r_seq   <= w_seq_nxt;
            r_idle  <= ~|r_busy;
        end
    end

    assign bus.thread_ack  = r_ack;
    assign bus.thread_done = r_done;
    assign bus.core_start  = r_start;
    assign bus.core_seq    = r_seq;
    assign bus.idle        = r_idle;
endmodule

// File: tb/tb_engine_sched.sv
// Randomized and directed bench for engine_sched against a time-based reference model
// (starts recorded by cycle, completion expected exactly FRAME cycles later).
module tb_engine_sched;
    localparam int N_CORES   = 3;
    localparam int N_THREADS = 2 * N_CORES;
    localparam int FRAME     = 144;
    localparam int CI        = FRAME / N_THREADS;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    engine_sched_if #(.N_CORES(N_CORES), .N_THREADS(N_THREADS)) bus ();

    engine_sched #(
        .N_CORES(N_CORES),
        .N_THREADS(N_THREADS),
        .FRAME(FRAME),
        .COMP_INTERVAL(CI)
    ) u_dut (
        .CLK(CLK),
        .reset(reset),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int                 cyc;
    int                 start_at [N_THREADS];
    logic [N_CORES-1:0] exp_seq;

    // observation log (from DUT outputs) for directed checks
    int ack_cyc  [N_THREADS];
    int done_cyc [N_THREADS];
    int ack_cnt  [N_THREADS];
    int first_ack;
    int n_starts;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int slot(input int t);
        return (t / N_CORES) * (FRAME / 2) + (t % N_CORES) * CI;
    endfunction

    task automatic clear_log;
        for (int t = 0; t < N_THREADS; t++) begin
            ack_cyc[t]  = -1;
            done_cyc[t] = -1;
            ack_cnt[t]  = 0;
        end
        first_ack = -1;
        n_starts  = 0;
    endtask

    // Reset asserted for one edge; the cycle after it is cycle 0.
    task automatic do_reset;
        reset = 1'b1;
        @(posedge CLK);
        #1;
        reset = 1'b0;
        cyc = 0;
        for (int t = 0; t < N_THREADS; t++) start_at[t] = -1;
        exp_seq = '0;
        check("rst_start", 32'(bus.core_start), 32'd0);
        check("rst_seq",   32'(bus.core_seq),   32'd0);
        check("rst_ack",   32'(bus.thread_ack), 32'd0);
        check("rst_done",  32'(bus.thread_done), 32'd0);
        check("rst_idle",  32'(bus.idle),       32'd1);
    endtask

    task automatic step(input logic [N_THREADS-1:0] req, input logic en_i);
        logic [N_THREADS-1:0] ea;
        logic [N_THREADS-1:0] ed;
        logic [N_CORES-1:0]   ecs;
        logic                 eidle;
        int                   pc;
        bus.thread_req = req;
        bus.en         = en_i;
        @(posedge CLK);
        #1;
        pc  = cyc % FRAME;
        cyc = cyc + 1;
        eidle = 1'b1;
        for (int t = 0; t < N_THREADS; t++) if (start_at[t] >= 0) eidle = 1'b0;
        ea  = '0;
        ed  = '0;
        ecs = '0;
        for (int t = 0; t < N_THREADS; t++) begin
            if (start_at[t] >= 0 && cyc == start_at[t] + FRAME) begin
                ed[t] = 1'b1;
                start_at[t] = -1;
            end
            if (pc == slot(t) && req[t] && en_i) begin
                ea[t] = 1'b1;
                start_at[t] = cyc;
                ecs[t % N_CORES] = 1'b1;
                exp_seq[t % N_CORES] = (t >= N_CORES);
            end
        end
        check("ack",   32'(bus.thread_ack),  32'(ea));
        check("done",  32'(bus.thread_done), 32'(ed));
        check("start", 32'(bus.core_start),  32'(ecs));
        check("seq",   32'(bus.core_seq),    32'(exp_seq));
        check("idle",  32'(bus.idle),        32'(eidle));
        check("ack_onehot",   32'($countones(bus.thread_ack) <= 1), 32'd1);
        check("start_onehot", 32'($countones(bus.core_start) <= 1), 32'd1);
        for (int t = 0; t < N_THREADS; t++) begin
            if (bus.thread_ack[t] === 1'b1) begin
                ack_cyc[t] = cyc;
                ack_cnt[t]++;
                if (first_ack < 0) first_ack = cyc;
            end
            if (bus.thread_done[t] === 1'b1) done_cyc[t] = cyc;
        end
        n_starts += $countones(bus.core_start);
    endtask

    initial begin
        bus.thread_req = '0;
        bus.en         = 1'b0;

        // single start of thread 0, req dropped after ack
        bus.thread_req = 6'b000001;
        bus.en = 1'b1;
        do_reset();
        clear_log();
        for (int i = 0; i < 150; i++) step((cyc == 0) ? 6'b000001 : 6'b000000, 1'b1);
        check("s1_ack_cyc",  32'(ack_cyc[0]),  32'd1);
        check("s1_done_cyc", 32'(done_cyc[0]), 32'd145);

        // second-half thread 4
        do_reset();
        clear_log();
        for (int i = 0; i < 250; i++) step((cyc <= 96) ? 6'b010000 : 6'b000000, 1'b1);
        check("s2_ack_cyc",  32'(ack_cyc[4]),  32'd97);
        check("s2_done_cyc", 32'(done_cyc[4]), 32'd241);

        // back-to-back on thread 2 for three frames
        do_reset();
        clear_log();
        for (int i = 0; i < 490; i++) step((cyc <= 336) ? 6'b000100 : 6'b000000, 1'b1);
        check("s3_ack_cnt",  32'(ack_cnt[2]),  32'd3);
        check("s3_last_ack", 32'(ack_cyc[2]),  32'd337);
        check("s3_last_done", 32'(done_cyc[2]), 32'd481);

        // every thread requesting for one frame
        do_reset();
        clear_log();
        for (int i = 0; i < 300; i++) step((cyc < FRAME) ? 6'b111111 : 6'b000000, 1'b1);
        check("s4_starts",    32'(n_starts),   32'd6);
        check("s4_first_ack", 32'(first_ack),  32'd1);
        check("s4_ack5",      32'(ack_cyc[5]), 32'd121);

        // en low until cycle 100
        do_reset();
        clear_log();
        for (int i = 0; i < 300; i++) step((cyc < FRAME) ? 6'b111111 : 6'b000000, cyc >= 100);
        check("s5_first_ack", 32'(first_ack), 32'd121);
        check("s5_starts",    32'(n_starts),  32'd1);

        // reset mid-flight abandons thread 0
        do_reset();
        clear_log();
        step(6'b000001, 1'b1);
        while (cyc < 60) step(6'b000000, 1'b1);
        check("s6_ack_pre", 32'(ack_cyc[0]), 32'd1);
        do_reset();
        clear_log();
        step(6'b000001, 1'b1);
        for (int i = 0; i < 299; i++) step(6'b000000, 1'b1);
        check("s6_ack_post",  32'(ack_cyc[0]),  32'd1);
        check("s6_done_post", 32'(done_cyc[0]), 32'd145);

        // random requests and enable
        do_reset();
        clear_log();
        for (int i = 0; i < 5 * FRAME; i++) begin
            step(N_THREADS'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < FRAME + 2; i++) step(6'b000000, 1'b0);
        check("rnd_idle_end", 32'(bus.idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
